mul_byte_seq: RTL and testbench
===============================

# mul_byte_seq

Sequential 8x8 byte multiplier producing a 16-bit product over a valid/ready handshake. It is the multiply-side counterpart of the combinational byte divider in the CPU execute stage. The execute stage issues operands, stalls on `in_ready`, and collects high and low product bytes when `out_valid` is asserted. It uses a one-bit-per-cycle shift-add datapath to keep area small.

## Interface
- `WIDTH`, default 8: operand width. Only 8 is supported.
- `clk` input 1: single clock. All state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operands `a`/`b` are valid.
- `in_ready` output 1: block can accept operands. Equals `(state == IDLE)`.
- `a` input 8: multiplicand.
- `b` input 8: multiplier.
- `is_signed` input 1: treat `a`/`b` as two's complement. Present only with `MUL_BYTE_SIGNED_EN`.
- `out_valid` output 1: product is valid and held.
- `out_ready` input 1: consumer accepts the product.
- `product_hi` output 8: product bits [15:8].
- `product_lo` output 8: product bits [7:0].
- `busy` output 1: high in CALC or DONE.

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid & in_ready`, latch the multiplicand magnitude into `mcand`, the multiplier magnitude into `mplier`, and the sign flag.
  - Clear the accumulator and set iteration count = 0.
  - Go to CALC.
- **CALC**, one iteration per edge:
  - If `mplier[0]`, add `mcand` into `acc[15:8]` with a 9-bit carry.
  - Shift `{carry, acc, mplier}` right by 1.
  - Increment the count.
  - After the 8th iteration (count == 7 at the edge), go to DONE.
  - Any sign correction is applied on that same edge (see Configuration).
  - `in_valid` is ignored.
- **DONE**
  - `out_valid` = 1; `product_hi`/`product_lo` are stable.
  - On `out_ready`, go to IDLE.
  - No new operand can be accepted while in DONE.
- Arithmetic rules:
  - Unsigned result is exact: `{hi,lo} = a*b`, mod 2^16, no overflow possible.
  - There is no early termination. A zero operand still takes the full latency.

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `busy` 0, `product_hi`/`product_lo` 0x00, internal registers 0.
- Latency: accepting edge E0. CALC occupies edges E1..E8. `out_valid` is high from just after E8.
- Handshake completes at the first edge Ek with `out_valid & out_ready`.
  - `in_ready` rises after Ek, so the earliest next accept is Ek+1.
  - Minimum initiation interval is 10 cycles.
- `out_ready` held high before DONE: the handshake completes on the first DONE edge.
- Backpressure: DONE is held indefinitely and the outputs must not change.
- Reset asserted mid-CALC or in DONE: immediate return to reset values and the in-flight result is discarded. The first edge after release can accept.
- `out_valid` and `in_ready` are never high simultaneously.

## Configuration
- `MUL_BYTE_SIGNED_EN` defined:
  - The `is_signed` port exists.
  - When it is latched as 1, each operand is converted to its magnitude at accept: `x[7] ? (~x + 1) : x`.
  - The result sign is `a[7] ^ b[7]`.
  - On the final CALC edge, a negative result is written as `~P + 1` over 16 bits.
  - Corner case: -128 * -128 = 0x4000.
- `MUL_BYTE_SIGNED_EN` undefined:
  - No `is_signed` port.
  - Unsigned only; no magnitude or negate logic is synthesized.

## Structure
- Shared package `mul_byte_pkg` holds:
  - the state enum `mul_state_t` {IDLE, CALC, DONE};
  - `MUL_WIDTH = 8`;
  - `MUL_ITERS = 8`;
  - `MUL_CNT_W = 3`.
- No sub-module. The datapath (adder, shifter, negator) stays inline in `mul_byte_seq`.

## Test plan
- Unsigned: `a=0xFF`, `b=0xFF` accepted at E0 -> `out_valid` after E8 with `{hi,lo}=0xFE01`. `busy` is high E1..handshake.
- Zero: `a=0x00`, `b=0x5A` -> `0x0000`, still after exactly 8 CALC edges.
- Backpressure: `a=0x12`, `b=0x34`, `out_ready` low for 5 cycles in DONE -> product stays 0x03A8, `in_ready` stays 0, and `in_valid` pulses are ignored. After the handshake, `in_ready` = 1 the next cycle.
- Signed (macro on, `is_signed=1`):
  - 0x80*0x80 -> 0x4000
  - 0x80*0x7F -> 0xC080
  - 0xFF*0x02 -> 0xFFFE
  - Same 0xFF*0x02 with `is_signed=0` -> 0x01FE.
- Reset: `a=0x0F`, `b=0x0F`, assert `reset_n` low after the 4th CALC edge -> outputs return to reset values immediately. After release, 0x03*0x05 -> 0x000F.
- Back-to-back: issue 0x10*0x10 then 0x02*0x80 with `in_valid` and `out_ready` held high -> 0x0100 then 0x0100, second accept exactly 10 cycles after the first.

Source files
------------

// File: rtl/mul_byte_pkg.sv
// Shared definitions for the sequential byte multiplier.
//   mul_state_t : FSM state encoding (IDLE, CALC, DONE)
//   MUL_WIDTH   : operand width
//   MUL_ITERS   : shift-add iterations per product
//   MUL_CNT_W   : width of the iteration counter
package mul_byte_pkg;

  localparam int unsigned MUL_WIDTH = 8;
  localparam int unsigned MUL_ITERS = 8;
  localparam int unsigned MUL_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_byte_seq.sv
// Sequential 8x8 shift-add multiplier with valid/ready handshakes on both sides.
// One multiplier bit is retired per clock; a product takes 8 CALC cycles after accept
// and is held in DONE until the consumer takes it.
//
// Optional feature: define MUL_BYTE_SIGNED_EN to add the is_signed port and
// two's-complement operand handling (magnitudes multiplied, result negated if needed).
//
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (a, b, and is_signed when enabled)
//   out_valid / out_ready : product handshake (product_hi, product_lo)
//   busy                  : high while a product is being computed or held
module mul_byte_seq
  import mul_byte_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MUL_BYTE_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic             busy
);

  localparam logic [MUL_CNT_W-1:0] LastCnt = MUL_CNT_W'(MUL_ITERS - 1);

  mul_state_t             state_q, state_d;
  logic [WIDTH-1:0]       mcand_q, mcand_d;
  logic [WIDTH-1:0]       mplier_q, mplier_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [MUL_CNT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]       a_mag, b_mag;
  logic [WIDTH:0]         sum;
  logic [2*WIDTH-1:0]     acc_shift;
  logic [2*WIDTH-1:0]     acc_final;

`ifdef MUL_BYTE_SIGNED_EN
  logic neg_q, neg_d;

  always_comb begin
    a_mag = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    b_mag = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  end

  always_comb begin
    acc_final = neg_q ? (~acc_shift + (2*WIDTH)'(1)) : acc_shift;
  end
`else
  assign a_mag     = a;
  assign b_mag     = b;
  assign acc_final = acc_shift;
`endif

  // One shift-add step: add into the upper half with carry, then shift
  // {carry, acc, mplier} right by one.
  always_comb begin
    sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
    acc_shift = {sum, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
`ifdef MUL_BYTE_SIGNED_EN
    neg_d    = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = '0;
`ifdef MUL_BYTE_SIGNED_EN
          neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
          state_d  = CALC;
        end
      end
      CALC: begin
        mplier_d = {acc_q[0], mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + MUL_CNT_W'(1);
        if (cnt_q == LastCnt) begin
          acc_d   = acc_final;
          state_d = DONE;
        end else begin
          acc_d   = acc_shift;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`ifdef MUL_BYTE_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`ifdef MUL_BYTE_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q == CALC) || (state_q == DONE);
  assign product_hi = acc_q[2*WIDTH-1:WIDTH];
  assign product_lo = acc_q[WIDTH-1:0];

endmodule

// File: tb/tb_mul_byte_seq.sv
// Self-checking bench for mul_byte_seq: directed vector table, multi-cycle corner
// sequences (reset mid-calculation, back-to-back issue) and randomized operands
// compared against an arithmetic reference model.
module tb_mul_byte_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       is_signed = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       in_ready, out_valid, busy;
  logic [7:0] product_hi, product_lo;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mul_byte_seq #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
`ifdef MUL_BYTE_SIGNED_EN
    .is_signed  (is_signed),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .product_hi (product_hi),
    .product_lo (product_lo),
    .busy       (busy)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    int          hold;
    logic [15:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y,
                                          input logic s);
    logic signed [15:0] sp;
    logic [15:0] up;
    if (s) begin
      sp = $signed(x) * $signed(y);
      return sp;
    end
    up = {8'h00, x} * {8'h00, y};
    return up;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #3;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Call #1 after a clock edge with the DUT idle. Returns product and edges from
  // accept to out_valid; holds out_ready low for 'hold' DONE cycles.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                        input int hold, output logic [15:0] prod, output int lat);
    a = ta;
    b = tb_v;
    is_signed = ts;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    is_signed = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      check("busy_calc", {31'd0, busy}, 32'd1);
      check("in_ready_calc", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    prod = {product_hi, product_lo};
    if (!out_valid) begin
      check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
      do_reset();
      return;
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      @(posedge clk);
      #1;
      check("hold_product", {16'd0, product_hi, product_lo}, {16'd0, prod});
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_hs_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vec_t        vecs[$];
    logic [15:0] prod;
    int          lat;

    // Reset state
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_product", {16'd0, product_hi, product_lo}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    vecs.push_back('{8'hFF, 8'hFF, 1'b0, 0, 16'hFE01});
    vecs.push_back('{8'h00, 8'h5A, 1'b0, 0, 16'h0000});
    vecs.push_back('{8'h12, 8'h34, 1'b0, 5, 16'h03A8});
    vecs.push_back('{8'h80, 8'h7F, 1'b0, 1, 16'h3F80});
    vecs.push_back('{8'hFF, 8'h02, 1'b0, 0, 16'h01FE});
`ifdef MUL_BYTE_SIGNED_EN
    vecs.push_back('{8'h80, 8'h80, 1'b1, 0, 16'h4000});
    vecs.push_back('{8'h80, 8'h7F, 1'b1, 2, 16'hC080});
    vecs.push_back('{8'hFF, 8'h02, 1'b1, 0, 16'hFFFE});
    vecs.push_back('{8'h05, 8'hFD, 1'b1, 0, 16'hFFF1});
`endif

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].hold, prod, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
      check($sformatf("vec%0d_product", i), {16'd0, prod}, {16'd0, vecs[i].exp});
    end

    // Reset after the 4th CALC edge discards the in-flight product
    a = 8'h0F;
    b = 8'h0F;
    is_signed = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_product", {16'd0, product_hi, product_lo}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(8'h03, 8'h05, 1'b0, 0, prod, lat);
    check("postrst_latency", 32'(lat), 32'd8);
    check("postrst_product", {16'd0, prod}, 32'h000F);

    // Back-to-back issue with in_valid and out_ready held high
    begin
      int          acc0 = -1;
      int          acc1 = -1;
      int          nprod = 0;
      logic [15:0] p[2];
      a = 8'h10;
      b = 8'h10;
      is_signed = 1'b0;
      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 40 && nprod < 2; i++) begin
        if (in_valid && in_ready) begin
          if (acc0 < 0) acc0 = i;
          else if (acc1 < 0) acc1 = i;
        end
        if (out_valid && out_ready) begin
          p[nprod] = {product_hi, product_lo};
          nprod++;
        end
        check("valid_ready_exclusive", {31'd0, out_valid & in_ready}, 32'd0);
        @(posedge clk);
        #1;
        if (acc0 == i) begin
          a = 8'h02;
          b = 8'h80;
        end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("b2b_count", 32'(nprod), 32'd2);
      check("b2b_first", {16'd0, p[0]}, 32'h0100);
      check("b2b_second", {16'd0, p[1]}, 32'h0100);
      check("b2b_interval", 32'(acc1 - acc0), 32'd10);
    end

    // Randomized operands against the reference model
    for (int i = 0; i < 24; i++) begin
      logic [7:0] ra, rb;
      logic       rs;
      ra = 8'($urandom);
      rb = 8'($urandom);
`ifdef MUL_BYTE_SIGNED_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, rs, int'($urandom_range(0, 3)), prod, lat);
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'd8);
      check($sformatf("rnd%0d_product a=%0h b=%0h s=%0d", i, ra, rb, rs), {16'd0, prod},
            {16'd0, ref_mul(ra, rb, rs)});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
